// File: rtl/multicycle_control.sv
// Hardwired control sequencer for the 8-bit teaching CPU: a one-hot beat ring
// plus opcode decode into per-beat datapath strobes, with halt, trap and watchdog.
module multicycle_control #(
    parameter int NT    = 8,
    parameter int ICW   = 16,
    parameter int ALUSW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cpustate,
    input  logic [7:0]       din,
    input  logic             z,
    output logic             read,
    output logic             write,
    output logic             arload,
    output logic             arinc,
    output logic             pcinc,
    output logic             pcload,
    output logic             drload,
    output logic             trload,
    output logic             irload,
    output logic             r0load,
    output logic             r1load,
    output logic             xload,
    output logic             zload,
    output logic             pcbus,
    output logic             drhbus,
    output logic             drlbus,
    output logic             trbus,
    output logic             r0bus,
    output logic             r1bus,
    output logic             membus,
    output logic             busmem,
    output logic [ALUSW-1:0] alus,
    output logic             clr,
    output logic [NT-1:0]    beat,
    output logic             halted,
    output logic             ill,
    output logic [ICW-1:0]   icount
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_NOT  = 4'd5,
        OP_LDI  = 4'd6,
        OP_JMPZ = 4'd7,
        OP_HALT = 4'd8
    } opcode_e;

    logic [NT-1:0]  beat_q, beat_d;
    logic           halted_q, halted_d;
    logic           ill_q, ill_d;
    logic [ICW-1:0] icount_q, icount_d;

    logic    run;
    logic    illegal;
    logic    halt_op;
    logic    wd_trip;
    opcode_e op;

    assign run     = (cpustate == 2'b11) && !rst;
    assign op      = opcode_e'(din[7:4]);
    assign illegal = (din[3:0] != 4'd0) || (din[7:4] > 4'd8);
    assign halt_op = (op == OP_HALT) && !illegal;

    assign beat   = beat_q;
    assign halted = halted_q;
    assign ill    = ill_q;
    assign icount = icount_q;

    // Jmpz beyond t3 only exists on the taken path, so z needs no capture register.
    always_comb begin
        read = 1'b0;  write = 1'b0;  arload = 1'b0; arinc = 1'b0;
        pcinc = 1'b0; pcload = 1'b0; drload = 1'b0; trload = 1'b0;
        irload = 1'b0; r0load = 1'b0; r1load = 1'b0; xload = 1'b0;
        zload = 1'b0; pcbus = 1'b0; drhbus = 1'b0; drlbus = 1'b0;
        trbus = 1'b0; r0bus = 1'b0; r1bus = 1'b0; membus = 1'b0;
        busmem = 1'b0;
        alus = '0;
        clr = 1'b0;
        wd_trip = 1'b0;
        if (run && !halted_q) begin
            if (beat_q[0]) begin
                pcbus = 1'b1; arload = 1'b1;
            end
            if (beat_q[1]) begin
                read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1;
            end
            if (beat_q[2]) begin
                drlbus = 1'b1; irload = 1'b1;
            end
            if (illegal) begin
                clr = beat_q[3];
            end else begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        if (beat_q[3]) begin
                            r0bus = 1'b1; xload = 1'b1; alus = ALUSW'(din[7:4]);
                        end
                        if (beat_q[4]) begin
                            r1bus = 1'b1; r0load = 1'b1; zload = 1'b1; clr = 1'b1;
                            alus = ALUSW'(din[7:4]);
                        end
                    end
                    OP_NOT: begin
                        if (beat_q[3]) begin
                            r0bus = 1'b1; r0load = 1'b1; zload = 1'b1; clr = 1'b1;
                            alus = ALUSW'(din[7:4]);
                        end
                    end
                    OP_LDI: begin
                        if (beat_q[3]) begin
                            pcbus = 1'b1; arload = 1'b1;
                        end
                        if (beat_q[4]) begin
                            read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1;
                        end
                        if (beat_q[5]) begin
                            drlbus = 1'b1; r0load = 1'b1; clr = 1'b1;
                        end
                    end
                    OP_JMPZ: begin
                        if (beat_q[3]) begin
                            if (z) begin
                                pcbus = 1'b1; arload = 1'b1;
                            end else begin
                                pcinc = 1'b1; clr = 1'b1;
                            end
                        end
                        if (beat_q[4]) begin
                            read = 1'b1; membus = 1'b1; drload = 1'b1;
                        end
                        if (beat_q[5]) begin
                            drlbus = 1'b1; pcload = 1'b1; clr = 1'b1;
                        end
                    end
                    OP_HALT: begin
                    end
                    default: clr = beat_q[3];
                endcase
            end
            if (beat_q[NT-1] && !clr) begin
                clr = 1'b1;
                wd_trip = 1'b1;
            end
        end
    end

    // A halted sequencer parks on t3 until reset; a frozen one holds every register.
    always_comb begin
        beat_d   = beat_q;
        halted_d = halted_q;
        ill_d    = ill_q;
        icount_d = icount_q;
        if (run && !halted_q) begin
            if (clr) begin
                beat_d   = {{(NT-1){1'b0}}, 1'b1};
                icount_d = icount_q + ICW'(1);
            end else if (beat_q[3] && halt_op) begin
                halted_d = 1'b1;
            end else begin
                beat_d = {beat_q[NT-2:0], beat_q[NT-1]};
            end
            if ((beat_q[3] && illegal) || wd_trip) begin
                ill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q   <= {{(NT-1){1'b0}}, 1'b1};
            halted_q <= 1'b0;
            ill_q    <= 1'b0;
            icount_q <= '0;
        end else begin
            beat_q   <= beat_d;
            halted_q <= halted_d;
            ill_q    <= ill_d;
            icount_q <= icount_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cpustate = 2'b11;
    logic [7:0]  din = 8'h10;
    logic        z = 1'b0;
    logic        read, write, arload, arinc, pcinc, pcload, drload, trload, irload;
    logic        r0load, r1load, xload, zload, pcbus, drhbus, drlbus, trbus;
    logic        r0bus, r1bus, membus, busmem;
    logic [3:0]  alus;
    logic        clr;
    logic [7:0]  beat;
    logic        halted, ill;
    logic [15:0] icount;
    logic [20:0] strobes;

    int checkCount = 0;
    int errorCount = 0;

    multicycle_control #(.NT(8), .ICW(16), .ALUSW(4)) dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .din(din), .z(z),
        .read(read), .write(write), .arload(arload), .arinc(arinc),
        .pcinc(pcinc), .pcload(pcload), .drload(drload), .trload(trload),
        .irload(irload), .r0load(r0load), .r1load(r1load), .xload(xload),
        .zload(zload), .pcbus(pcbus), .drhbus(drhbus), .drlbus(drlbus),
        .trbus(trbus), .r0bus(r0bus), .r1bus(r1bus), .membus(membus),
        .busmem(busmem), .alus(alus), .clr(clr), .beat(beat),
        .halted(halted), .ill(ill), .icount(icount)
    );

    assign strobes = {read, write, arload, arinc, pcinc, pcload, drload, trload,
                      irload, r0load, r1load, xload, zload, pcbus, drhbus, drlbus,
                      trbus, r0bus, r1bus, membus, busmem};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Step to the next falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input int beats);
        repeat (beats) @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        applyStimulus(1);
        checkOutput("rst_beat", 32'(beat), 32'h01);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_ill", 32'(ill), 32'd0);
        checkOutput("rst_icount", 32'(icount), 32'd0);
        checkOutput("rst_strobes", 32'(strobes), 32'd0);
        checkOutput("rst_clr", 32'(clr), 32'd0);

        // add: 5 beats
        rst = 1'b0;
        #1;
        checkOutput("add_t0_pcbus", 32'(pcbus), 32'd1);
        checkOutput("add_t0_arload", 32'(arload), 32'd1);
        applyStimulus(1);
        checkOutput("add_t1_beat", 32'(beat), 32'h02);
        checkOutput("add_t1_fetch", 32'({read, membus, drload, pcinc}), 32'hF);
        applyStimulus(1);
        checkOutput("add_t2_fetch", 32'({drlbus, irload}), 32'h3);
        applyStimulus(1);
        checkOutput("add_t3_beat", 32'(beat), 32'h08);
        checkOutput("add_t3_bus", 32'({r0bus, xload, clr}), 32'h6);
        checkOutput("add_t3_alus", 32'(alus), 32'h1);
        applyStimulus(1);
        checkOutput("add_t4_beat", 32'(beat), 32'h10);
        checkOutput("add_t4_ctl", 32'({r1bus, r0load, zload, clr}), 32'hF);
        checkOutput("add_t4_alus", 32'(alus), 32'h1);
        applyStimulus(1);
        checkOutput("add_done_beat", 32'(beat), 32'h01);
        checkOutput("add_done_icount", 32'(icount), 32'd1);

        // jmpz not taken: 4 beats
        din = 8'h70;
        z   = 1'b0;
        applyStimulus(3);
        checkOutput("jnz_t3_pcinc", 32'(pcinc), 32'd1);
        checkOutput("jnz_t3_clr", 32'(clr), 32'd1);
        checkOutput("jnz_t3_alus", 32'(alus), 32'd0);
        applyStimulus(1);
        checkOutput("jnz_done_beat", 32'(beat), 32'h01);
        checkOutput("jnz_done_icount", 32'(icount), 32'd2);

        // jmpz taken: 6 beats; z dropping after t3 must not change the path
        z = 1'b1;
        applyStimulus(3);
        checkOutput("jz_t3", 32'({pcbus, arload, pcinc, clr}), 32'hC);
        applyStimulus(1);
        z = 1'b0;
        #1;
        checkOutput("jz_t4", 32'({read, membus, drload, pcinc, clr}), 32'h1C);
        applyStimulus(1);
        checkOutput("jz_t5_beat", 32'(beat), 32'h20);
        checkOutput("jz_t5", 32'({drlbus, pcload, clr}), 32'h7);
        applyStimulus(1);
        checkOutput("jz_done_beat", 32'(beat), 32'h01);
        checkOutput("jz_done_icount", 32'(icount), 32'd3);

        // ldi: 6 beats, pcinc at t1 and t4
        din = 8'h60;
        applyStimulus(1);
        checkOutput("ldi_t1_pcinc", 32'(pcinc), 32'd1);
        applyStimulus(2);
        checkOutput("ldi_t3", 32'({pcbus, arload, clr}), 32'h6);
        applyStimulus(1);
        checkOutput("ldi_t4_pcinc", 32'(pcinc), 32'd1);
        checkOutput("ldi_t4_clr", 32'(clr), 32'd0);
        applyStimulus(1);
        checkOutput("ldi_t5", 32'({drlbus, r0load, clr, pcload}), 32'hE);
        applyStimulus(1);
        checkOutput("ldi_done_icount", 32'(icount), 32'd4);

        // halt: parks on t3 with no strobes until reset
        din = 8'h80;
        applyStimulus(3);
        checkOutput("halt_t3_strobes", 32'(strobes), 32'd0);
        checkOutput("halt_t3_clr", 32'(clr), 32'd0);
        checkOutput("halt_t3_halted", 32'(halted), 32'd0);
        applyStimulus(1);
        checkOutput("halt_set", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            checkOutput("halt_hold_beat", 32'(beat), 32'h08);
            checkOutput("halt_hold_strobes", 32'({strobes, clr}), 32'd0);
            applyStimulus(1);
        end
        checkOutput("halt_icount", 32'(icount), 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("halt_rst_beat", 32'(beat), 32'h01);
        checkOutput("halt_rst_halted", 32'(halted), 32'd0);
        checkOutput("halt_rst_icount", 32'(icount), 32'd0);

        // illegal low nibble traps and retires; ill stays through 3 nops
        din = 8'h12;
        applyStimulus(1);
        rst = 1'b0;
        #1;
        applyStimulus(3);
        checkOutput("ill_t3_clr", 32'(clr), 32'd1);
        checkOutput("ill_t3_alus", 32'(alus), 32'd0);
        checkOutput("ill_before", 32'(ill), 32'd0);
        applyStimulus(1);
        checkOutput("ill_set", 32'(ill), 32'd1);
        checkOutput("ill_icount", 32'(icount), 32'd1);
        din = 8'h00;
        applyStimulus(3);
        checkOutput("nop_t3_clr", 32'(clr), 32'd1);
        applyStimulus(9);
        checkOutput("nop_beat", 32'(beat), 32'h01);
        checkOutput("ill_sticky", 32'(ill), 32'd1);
        checkOutput("nop_icount", 32'(icount), 32'd4);

        // opcode 9 also traps at t3
        din = 8'h90;
        applyStimulus(3);
        checkOutput("op9_t3_clr", 32'(clr), 32'd1);
        applyStimulus(1);
        checkOutput("op9_icount", 32'(icount), 32'd5);

        // freeze at t4 of an add, then resume
        din = 8'h10;
        applyStimulus(4);
        checkOutput("frz_t4_beat", 32'(beat), 32'h10);
        cpustate = 2'b01;
        #1;
        checkOutput("frz_strobes", 32'({strobes, clr}), 32'd0);
        checkOutput("frz_alus", 32'(alus), 32'd0);
        applyStimulus(3);
        checkOutput("frz_hold_beat", 32'(beat), 32'h10);
        checkOutput("frz_hold_icount", 32'(icount), 32'd5);
        cpustate = 2'b11;
        #1;
        checkOutput("resume_r0load", 32'(r0load), 32'd1);
        checkOutput("resume_clr", 32'(clr), 32'd1);
        applyStimulus(1);
        checkOutput("resume_beat", 32'(beat), 32'h01);
        checkOutput("resume_icount", 32'(icount), 32'd6);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised hardwired control sequencer for the 8-bit teaching CPU. It generates a one-hot beat ring of NT steps and decodes the IR opcode into per-beat datapath control strobes. It supports variable-length instructions, conditional jump on z, halt, illegal-opcode trapping and a beat-overrun watchdog. It sits between the IR/z flag and the register/ALU/memory datapath and replaces the fixed 8-beat controller.

## Interface
- NT, 8: beats per ring; legal range 6..16.
- ICW, 16: width of retired-instruction counter.
- ALUSW, 4: width of alus.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpustate  in  2  CPU mode; 2'b11 = RUN, other values = frozen.
- din  in  8  IR contents; opcode = din[7:4]; din[3:0] must be 0.
- z  in  1  zero flag.
- read, write, arload, arinc, pcinc, pcload, drload, trload, irload, r0load, r1load, xload, zload, pcbus, drhbus, drlbus, trbus, r0bus, r1bus, membus, busmem  out  1 each  datapath strobes.
- alus  out  ALUSW  ALU op select.
- clr  out  1  last beat of the current instruction.
- beat  out  NT  one-hot current beat, t0 = bit 0.
- halted  out  1  halt state.
- ill  out  1  sticky illegal/overrun flag.
- icount  out  ICW  count of retired instructions.

## Operation
- run = (cpustate == 2'b11) and not rst. All strobes and clr are combinational from beat, decode and z, ANDed with run. Strobes are 0 while rst is high or run is 0.
- Fetch, all opcodes: t0 pcbus, arload; t1 read, membus, drload, pcinc; t2 drlbus, irload.
- Decode is combinational from din during t3 onward. A nonzero din[3:0] means illegal.
- Execute beats:
  - 0 nop: t3 clr.
  - 1 add / 2 sub / 3 and / 4 or: t3 r0bus, xload; t4 r1bus, r0load, zload, clr. alus = 0001 / 0010 / 0011 / 0100.
  - 5 not: t3 r0bus, r0load, zload, clr; alus = 0101.
  - 6 ldi: t3 pcbus, arload; t4 read, membus, drload, pcinc; t5 drlbus, r0load, clr.
  - 7 jmpz with z=1: t3 pcbus, arload; t4 read, membus, drload; t5 drlbus, pcload, clr.
  - 7 jmpz with z=0: t3 pcinc, clr (skips the operand byte).
  - 8 halt: t3 and beyond assert no strobes; clr = 0.
  - 9..15 or illegal: t3 clr.
- alus is 0 for non-ALU opcodes and outside t3..t4.
- z is sampled combinationally at t3. The jmpz path is fixed by z at t3 and does not change if z changes later.

## Timing
- Reset (async, rst high): beat = t0 one-hot, halted = 0, ill = 0, icount = 0. All strobes, clr and alus are 0.
- Beat advance on each clk edge when run = 1:
  - clr = 1: beat goes to t0 and icount increments (wraps at 2^ICW).
  - Otherwise beat shifts one position.
- run = 0: beat, halted and icount hold. Resume continues at the same beat with no lost or repeated beat.
- Halt:
  - At the t3 edge with opcode 8, halted is set and beat holds at t3.
  - Leaving halt requires rst.
  - icount does not count a halt.
- ill:
  - Set on the t3 edge of an illegal opcode (9..15 or din[3:0] != 0). Sticky until rst. The instruction still retires.
- Watchdog:
  - If beat reaches t(NT-1) with clr = 0 and halted = 0, clr is forced high that beat and ill is set.
  - Unreachable for legal opcodes when NT ≥ 6.
- Instruction latency: fetch 3 beats, plus exec beats.
  - Exec: nop, not, illegal, jmpz not-taken = 1; ALU ops = 2; ldi, jmpz taken = 3.
- Reset mid-instruction aborts immediately. The first beat after release is t0.

## Test plan
- Reset then RUN with din = 8'h10 held: beat goes t0, t1, t2, t3, t4, t0. At t3 r0bus = xload = 1. At t4 r0load = zload = clr = 1 and alus = 4'b0001. icount = 1 after 5 edges.
- din = 8'h70, z = 0: clr at t3 with pcinc = 1; 4 beats total. Then z = 1: t5 has pcload = drlbus = 1; 6 beats total.
- din = 8'h60 (ldi): clr at t5; pcinc asserted at both t1 and t4.
- din = 8'h80: halted = 1 after the t3 edge. Beat holds at t3 for 20 cycles, strobes stay 0 and icount is unchanged. Asserting rst gives beat = t0 and halted = 0.
- din = 8'h12 (illegal low nibble): clr at t3 and ill = 1, staying 1 across 3 further nop instructions.
- Drop cpustate to 2'b01 at t4 of an add: strobes go to 0 and beat holds t4. Restoring 2'b11 gives r0load = 1 on the first cycle, then t0.
